// File: rtl/pipe_seg_skid_pkg.sv
// pipe_pkg: occupancy codes and per-stage payload widths shared by every pipe_seg_skid instance.
package pipe_pkg;
  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE = 2'd1;
  localparam logic [1:0] OCC_TWO = 2'd2;
  localparam int IF_ID_W = 64;
  localparam int ID_EX_W = 160;
  localparam int EX_MEM_W = 112;
  localparam int MEM_WB_W = 72;
endpackage

// File: rtl/pipe_seg_skid_slot.sv
// pipe_slot: one valid+payload holding register with a load enable and a flush/reset clear.
module pipe_slot #(
  parameter int DATA_W = 32,
  parameter bit CLEAR_PAYLOAD = 1'b1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              clr_i,
  input  logic              valid_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);
  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic              wipe;
  assign wipe = !resetn || clr_i;
  // With CLEAR_PAYLOAD=0 a wipe leaves the payload alone; only the valid bit matters then.
  always_ff @(posedge clk) begin
    valid_q <= wipe ? 1'b0 : valid_i;
    if (wipe && CLEAR_PAYLOAD) data_q <= '0;
    else if (load_i) data_q <= data_i;
  end
  assign valid_o = valid_q;
  assign data_o = data_q;
endmodule

// File: rtl/pipe_seg_skid.sv
// pipe_seg_skid: valid/ready inter-stage register with a 2-entry skid buffer and flush.
// Optional SEG_PERF_CNT_EN adds a 32-bit stall_cnt output counting out_valid & !out_ready cycles.
module pipe_seg_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter bit CLEAR_PAYLOAD = 1'b1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              refresh,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
`ifdef SEG_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);
  logic              main_valid, skid_valid, main_valid_d, skid_valid_d;
  logic              main_load, skid_load, accept, drain, skid_to_main;
  logic [DATA_W-1:0] main_data, skid_data, main_data_d;
  assign in_ready = !skid_valid;
  assign accept = in_valid && in_ready;
  assign drain = main_valid && out_ready;
  // Skid moves forward when main drains, or at once from the unreachable (0,1) state.
  assign skid_to_main = skid_valid && (drain || !main_valid);
  always_comb begin
    main_load = skid_to_main || (accept && (!main_valid || drain));
    main_data_d = skid_to_main ? skid_data : in_data;
    main_valid_d = skid_to_main || accept || (main_valid && !drain);
    skid_load = accept && main_valid && !drain;
    skid_valid_d = skid_load || (skid_valid && !skid_to_main);
  end
  pipe_slot #(.DATA_W(DATA_W), .CLEAR_PAYLOAD(CLEAR_PAYLOAD)) u_main (
    .clk(clk), .resetn(resetn), .clr_i(refresh), .valid_i(main_valid_d), .load_i(main_load),
    .data_i(main_data_d), .valid_o(main_valid), .data_o(main_data)
  );
  pipe_slot #(.DATA_W(DATA_W), .CLEAR_PAYLOAD(CLEAR_PAYLOAD)) u_skid (
    .clk(clk), .resetn(resetn), .clr_i(refresh), .valid_i(skid_valid_d), .load_i(skid_load),
    .data_i(in_data), .valid_o(skid_valid), .data_o(skid_data)
  );
  assign out_valid = main_valid;
  assign out_data = main_data;
  assign occupancy = (main_valid && skid_valid) ? OCC_TWO : (main_valid || skid_valid) ? OCC_ONE : OCC_EMPTY;
`ifdef SEG_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  always_ff @(posedge clk) stall_cnt_q <= !resetn ? 32'd0 : stall_cnt_q + {31'd0, main_valid && !out_ready};
  assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_pipe_seg_skid.sv
// tb_pipe_seg_skid: scenario tasks with inline checks plus a FIFO scoreboard on the output handshake.
module tb_pipe_seg_skid;
  localparam int W = 32;
  logic clk = 0, resetn = 0, refresh = 0, in_valid = 0, out_ready = 0;
  logic [W-1:0] in_data = '0;
  logic in_ready, out_valid;
  logic [W-1:0] out_data;
  logic [1:0] occupancy;
`ifdef SEG_PERF_CNT_EN
  logic [31:0] stall_cnt;
`endif
  int total = 0, bad = 0;
  logic [W-1:0] sb[$];

  pipe_seg_skid #(.DATA_W(W), .CLEAR_PAYLOAD(1'b1)) dut (
    .clk(clk), .resetn(resetn), .refresh(refresh), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
`ifdef SEG_PERF_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Scoreboard: pre-edge values decide what transfers on this edge.
  always @(posedge clk) begin
    if (!resetn) sb.delete();
    else begin
      if (out_valid && out_ready) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected: got out_data=%h, expected no output", out_data);
        end else begin
          logic [W-1:0] exp_d;
          exp_d = sb.pop_front();
          if (out_data !== exp_d) begin
            bad++;
            $display("FAIL sb_order: got out_data=%h, expected %h", out_data, exp_d);
          end
        end
      end
      if (refresh) sb.delete();
      else if (in_valid && in_ready) sb.push_back(in_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(string nm, logic ov, logic ir, logic [1:0] occ);
    total++;
    if (out_valid !== ov || in_ready !== ir || occupancy !== occ) begin
      bad++;
      $display("FAIL %s: got out_valid=%b in_ready=%b occ=%0d, expected %b %b %0d",
               nm, out_valid, in_ready, occupancy, ov, ir, occ);
    end
  endtask

  task automatic test_reset();
    resetn = 0;
    tick();
    tick();
    resetn = 1;
    expect_state("reset_state", 1'b0, 1'b1, 2'd0);
    total++;
    if (out_data !== '0) begin
      bad++;
      $display("FAIL reset_data: got %h, expected 0", out_data);
    end
  endtask

  task automatic test_streaming();
    logic [W-1:0] v[3] = '{32'h11, 32'h22, 32'h33};
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1;
      in_data = v[i];
      tick();
      expect_state("stream_state", 1'b1, 1'b1, 2'd1);
      total++;
      if (out_data !== v[i]) begin
        bad++;
        $display("FAIL stream_data: got %h, expected %h", out_data, v[i]);
      end
    end
    in_valid = 0;
    tick();
    expect_state("stream_end", 1'b0, 1'b1, 2'd0);
  endtask

  task automatic push_two(logic [W-1:0] a, logic [W-1:0] b);
    out_ready = 0;
    in_valid = 1;
    in_data = a;
    tick();
    expect_state("bp_first", 1'b1, 1'b1, 2'd1);
    in_data = b;
    tick();
    in_valid = 0;
    expect_state("bp_full", 1'b1, 1'b0, 2'd2);
  endtask

  task automatic test_backpressure();
    push_two(32'hA, 32'hB);
    tick();
    expect_state("bp_hold", 1'b1, 1'b0, 2'd2);
    total++;
    if (out_data !== 32'hA) begin
      bad++;
      $display("FAIL bp_hold_data: got %h, expected %h", out_data, 32'hA);
    end
    out_ready = 1;
    tick();
    expect_state("bp_drain1", 1'b1, 1'b1, 2'd1);
    total++;
    if (out_data !== 32'hB) begin
      bad++;
      $display("FAIL bp_drain_data: got %h, expected %h", out_data, 32'hB);
    end
    tick();
    expect_state("bp_drain2", 1'b0, 1'b1, 2'd0);
    out_ready = 0;
  endtask

  task automatic test_refresh_skid();
    push_two(32'hA, 32'hB);
    in_valid = 1;
    in_data = 32'hC;
    refresh = 1;
    tick();
    refresh = 0;
    in_valid = 0;
    expect_state("refresh_skid", 1'b0, 1'b1, 2'd0);
    total++;
    if (out_data !== '0) begin
      bad++;
      $display("FAIL refresh_data: got %h, expected 0", out_data);
    end
    // In FULL in_ready reads 1, yet the item offered during refresh must vanish.
    in_valid = 1;
    in_data = 32'hD;
    tick();
    in_data = 32'hE;
    refresh = 1;
    tick();
    refresh = 0;
    in_valid = 0;
    expect_state("refresh_full", 1'b0, 1'b1, 2'd0);
    out_ready = 1;
    tick();
    tick();
    expect_state("refresh_quiet", 1'b0, 1'b1, 2'd0);
    out_ready = 0;
  endtask

  task automatic test_reset_priority();
    in_valid = 1;
    in_data = 32'h5A;
    tick();
    expect_state("prio_full", 1'b1, 1'b1, 2'd1);
    in_data = 32'h77;
    resetn = 0;
    refresh = 1;
    tick();
    resetn = 1;
    refresh = 0;
    in_valid = 0;
    expect_state("prio_state", 1'b0, 1'b1, 2'd0);
    total++;
    if (out_data !== '0) begin
      bad++;
      $display("FAIL prio_data: got %h, expected 0", out_data);
    end
`ifdef SEG_PERF_CNT_EN
    total++;
    if (stall_cnt !== 32'd0) begin
      bad++;
      $display("FAIL prio_stall: got %0d, expected 0", stall_cnt);
    end
`endif
  endtask

`ifdef SEG_PERF_CNT_EN
  task automatic test_perf();
    out_ready = 0;
    in_valid = 1;
    in_data = 32'h99;
    tick();
    in_valid = 0;
    repeat (5) tick();
    total++;
    if (stall_cnt !== 32'd5) begin
      bad++;
      $display("FAIL perf_count: got %0d, expected 5", stall_cnt);
    end
    out_ready = 1;
    refresh = 1;
    tick();
    refresh = 0;
    out_ready = 0;
    tick();
    total++;
    if (stall_cnt !== 32'd5) begin
      bad++;
      $display("FAIL perf_after_refresh: got %0d, expected 5", stall_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_refresh_skid();
    test_reset_priority();
`ifdef SEG_PERF_CNT_EN
    test_perf();
`endif
    tick();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover: got %0d pending items, expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_seg_skid.md
Name: pipe_seg_skid

Overview:
- Parametrised successor to the fixed-field inter-stage registers; carries an opaque payload bus between two pipeline stages.
- Adds a valid/ready handshake and a 2-entry skid buffer, so back-pressure does not have to be combinational from the downstream stage to the upstream one.
- Keeps the existing refresh (flush) semantics and reset-to-zero convention.
- Drops in between any two stages (if/id, id/ex, ex/mem, mem/wb) with the payload width chosen per instance.

Parameters:
- DATA_W, 32, payload width in bits (≥1).
- CLEAR_PAYLOAD, 1, 1 = payload registers zeroed on reset/refresh; 0 = only valid bits cleared (saves enable fan-out).

Ports:
- clk  in  1  clock, all state updates on posedge.
- resetn  in  1  synchronous, active-low reset.
- refresh  in  1  flush: discard all held entries this edge.
- in_valid  in  1  upstream presents payload.
- in_ready  out  1  stage can accept; registered (= !skid_valid).
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  DATA_W  payload to downstream (main register).
- occupancy  out  2  held entries, 0..2.

Behaviour:
- Storage:
  - main entry (main_valid, main_data) drives out_*.
  - skid entry (skid_valid, skid_data) holds one overflow item.
- Handshakes:
  - accept = in_valid & in_ready.
  - drain = out_valid & out_ready.
  - Transfers occur on the posedge where the handshake is true.
- in_ready = !skid_valid, taken straight from a flop with no combinational path from out_ready.
- out_valid = main_valid; out_data = main_data; occupancy = main_valid + skid_valid.
- States, as (main_valid, skid_valid):
  - EMPTY (0,0):
    - accept → FULL, main_data <= in_data.
  - FULL (1,0):
    - accept & drain → FULL, main <= in_data (throughput 1/cycle).
    - accept & !drain → SKID, skid <= in_data.
    - !accept & drain → EMPTY.
    - otherwise hold.
  - SKID (1,1), with in_ready = 0:
    - drain → FULL, main <= skid, skid_valid <= 0.
    - otherwise hold.
  - (0,1) is unreachable; from it the block must recover to FULL on the next edge.
- Latency: 1 cycle from accept to out_valid when the stage is empty; ordering is strictly FIFO.
- Priority per edge: !resetn > refresh > normal update.
- Reset (!resetn at posedge):
  - main_valid = skid_valid = 0, giving in_ready = 1, out_valid = 0, occupancy = 0.
  - main_data = skid_data = 0 when CLEAR_PAYLOAD = 1; otherwise they are don't-care.
- Refresh:
  - Same effect as reset on the valid bits and payload.
  - An item presented with in_valid in the refresh cycle is dropped, even though in_ready may read 1.
  - drain in the refresh cycle still completes downstream; the item is not retained.
- Reset or refresh while in SKID discards both entries with no partial state.
- Payload bits are never modified or interpreted; width DATA_W throughout, no truncation.
- Holding without drain: out_data must stay stable while out_valid & !out_ready (AXI-style rule).

Optional Feature:
- Macro SEG_PERF_CNT_EN.
- Defined:
  - Adds output stall_cnt [31:0], which increments on every cycle with out_valid & !out_ready.
  - Wraps modulo 2^32.
  - Cleared by reset only, not by refresh.
- Undefined: port and counter are absent; behaviour otherwise identical.

Decomposition:
- Shared package pipe_pkg:
  - occupancy encodings (OCC_EMPTY = 0, OCC_ONE = 1, OCC_TWO = 2).
  - Per-stage payload width localparams (e.g. MEM_WB_W), so each instance sizes DATA_W from the package.
- Sub-module: none required. The skid slot may optionally be factored into pipe_slot (valid + data flop with load/clear), instanced twice.

Test Plan:
- Reset: hold resetn = 0 for 2 cycles, then release → in_ready = 1, out_valid = 0, occupancy = 0, out_data = 0 (CLEAR_PAYLOAD = 1).
- Streaming: out_ready = 1, present 0x11, 0x22, 0x33 on consecutive cycles → out_data 0x11, 0x22, 0x33 one cycle later each, in_ready stays 1, occupancy ≤ 1.
- Back-pressure: out_ready = 0, push 0xA, 0xB → occupancy = 2, in_ready = 0, out_data = 0xA held. Raise out_ready → out 0xA, then 0xB; in_ready = 1 one edge after the first drain.
- Refresh in SKID: hold (0xA, 0xB), pulse refresh with in_valid = 1 and in_data = 0xC → next cycle occupancy = 0, out_valid = 0, 0xC never emitted.
- Reset priority: resetn = 0 and refresh = 1 together while in FULL → all state cleared identically to reset. With SEG_PERF_CNT_EN, stall_cnt = 0.
- Perf counter (SEG_PERF_CNT_EN): 5 cycles of out_valid & !out_ready, then a refresh → stall_cnt = 5, still 5 after the refresh.
